cmi_packet_responder: RTL and testbench

Far-end (slave) protocol engine for the CMI single-packet link. It parses the byte stream from the UART receiver into CMI frames sent by the packet manager, presents each valid frame to user logic, and answers it with one reply frame built from local data. It sits between `rs232_rx`/`rs232_tx` and the remote-side application logic, so no timeslot generator is needed at this end.

---
 rtl/cmi_packet_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_cmi_packet_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmi_packet_responder.sv
// CMI far-end responder: parses 11-byte CMI frames from the UART receiver and answers each one with a reply frame.
// Optional macro CMI_RESPONDER_TIMEOUT_EN compiles in the inter-byte timeout that abandons stalled frames.
module cmi_packet_responder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [1:0]  REPLY_TYPE   = 2'b01,
    parameter int unsigned TIMEOUT_CLKS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_ena,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic [15:0] cmi_self0,
    input  logic [15:0] cmi_self1,
    input  logic [15:0] cmi_self2,
    input  logic [15:0] cmi_self3,
    output logic [7:0]  cmi_head,
    output logic [15:0] cmi_data0,
    output logic [15:0] cmi_data1,
    output logic [15:0] cmi_data2,
    output logic [15:0] cmi_data3,
    output logic        cmi_rdy,
    output logic        cmi_fault,
    output logic        cmi_overrun
);

    typedef enum logic [1:0] {R_IDLE, R_HEAD, R_DATA, R_CSUM} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND, T_GAP} tx_state_t;

    rx_state_t   rx_state_q;
    logic [7:0]  head_sh_q;
    logic [15:0] data_sh_q [4];
    logic [7:0]  xor_q;
    logic [2:0]  idx_q;
    logic [7:0]  head_q;
    logic [15:0] data_q [4];
    logic        rdy_q;
    logic        fault_q;
    logic        timeout_hit;

    tx_state_t   tx_state_q;
    logic [15:0] snap_q [4];
    logic [7:0]  snap_head_q;
    logic [7:0]  csum_q;
    logic [3:0]  byte_idx_q;
    logic [7:0]  tx_last_q;
    logic [15:0] self_w [4];
    logic [15:0] fold_w;
    logic [7:0]  csum_d;
    logic [2:0]  byte_rel;
    logic [15:0] pick_w;
    logic [7:0]  cur_byte;

    assign self_w[0] = cmi_self0;
    assign self_w[1] = cmi_self1;
    assign self_w[2] = cmi_self2;
    assign self_w[3] = cmi_self3;

`ifdef CMI_RESPONDER_TIMEOUT_EN
    logic [15:0] idle_cnt_q;

    // Only counts while a frame is open; any received byte restarts the wait.
    assign timeout_hit = (rx_state_q != R_IDLE) && !rx_ena &&
                         (idle_cnt_q == 16'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= 16'd0;
        end else if (rx_state_q == R_IDLE || rx_ena || timeout_hit) begin
            idle_cnt_q <= 16'd0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
        end
    end
`else
    logic timeout_unused;

    assign timeout_hit    = 1'b0;
    assign timeout_unused = (TIMEOUT_CLKS != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            head_sh_q  <= 8'd0;
            xor_q      <= 8'd0;
            idx_q      <= 3'd0;
            head_q     <= 8'd0;
            rdy_q      <= 1'b0;
            fault_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_sh_q[i] <= 16'd0;
                data_q[i]    <= 16'd0;
            end
        end else begin
            rdy_q   <= 1'b0;
            fault_q <= 1'b0;
            if (timeout_hit) begin
                rx_state_q <= R_IDLE;
                fault_q    <= 1'b1;
            end else if (rx_ena) begin
                case (rx_state_q)
                    R_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            rx_state_q <= R_HEAD;
                        end
                    end
                    R_HEAD: begin
                        head_sh_q  <= rx_data;
                        xor_q      <= rx_data;
                        idx_q      <= 3'd0;
                        rx_state_q <= R_DATA;
                    end
                    R_DATA: begin
                        // Even index is the high byte of word idx/2.
                        if (!idx_q[0]) begin
                            data_sh_q[idx_q[2:1]][15:8] <= rx_data;
                        end else begin
                            data_sh_q[idx_q[2:1]][7:0] <= rx_data;
                        end
                        xor_q <= xor_q ^ rx_data;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            rx_state_q <= R_CSUM;
                        end
                    end
                    R_CSUM: begin
                        if (rx_data == xor_q) begin
                            head_q <= head_sh_q;
                            for (int i = 0; i < 4; i++) begin
                                data_q[i] <= data_sh_q[i];
                            end
                            rdy_q <= 1'b1;
                        end else begin
                            fault_q <= 1'b1;
                        end
                        rx_state_q <= R_IDLE;
                    end
                    default: rx_state_q <= R_IDLE;
                endcase
            end
        end
    end

    assign cmi_head    = head_q;
    assign cmi_data0   = data_q[0];
    assign cmi_data1   = data_q[1];
    assign cmi_data2   = data_q[2];
    assign cmi_data3   = data_q[3];
    assign cmi_rdy     = rdy_q;
    assign cmi_fault   = fault_q;
    assign cmi_overrun = rdy_q && (tx_state_q != T_IDLE);

    always_comb begin
        fold_w = snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3];
        csum_d = snap_head_q ^ fold_w[15:8] ^ fold_w[7:0];
    end

    // Reply byte selection: 0 sync, 1 header, 2..9 payload high-first, 10 checksum.
    always_comb begin
        byte_rel = 3'(byte_idx_q - 4'd2);
        pick_w   = snap_q[byte_rel[2:1]];
        cur_byte = csum_q;
        if (byte_idx_q == 4'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (byte_idx_q == 4'd1) begin
            cur_byte = snap_head_q;
        end else if (byte_idx_q <= 4'd9) begin
            cur_byte = byte_rel[0] ? pick_w[7:0] : pick_w[15:8];
        end
    end

    // The strobe reacts to tx_busy in the same cycle so the first byte can leave two clocks after cmi_rdy.
    assign tx_enable = (tx_state_q == T_SEND) && !tx_busy;
    assign tx_data   = tx_enable ? cur_byte : tx_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= T_IDLE;
            snap_head_q <= 8'd0;
            csum_q      <= 8'd0;
            byte_idx_q  <= 4'd0;
            tx_last_q   <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= 16'd0;
            end
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (rdy_q) begin
                        for (int i = 0; i < 4; i++) begin
                            snap_q[i] <= self_w[i];
                        end
                        snap_head_q <= {head_q[7:2], REPLY_TYPE};
                        byte_idx_q  <= 4'd0;
                        tx_state_q  <= T_LOAD;
                    end
                end
                T_LOAD: begin
                    csum_q     <= csum_d;
                    tx_state_q <= T_SEND;
                end
                T_SEND: begin
                    if (!tx_busy) begin
                        tx_last_q <= cur_byte;
                        if (byte_idx_q == 4'd10) begin
                            tx_state_q <= T_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 4'd1;
                            tx_state_q <= T_GAP;
                        end
                    end
                end
                T_GAP: begin
                    tx_state_q <= T_SEND;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmi_packet_responder.sv
// Randomised bench for cmi_packet_responder with a frame-level reference model checked every cycle.
module tb_cmi_packet_responder;

`ifdef CMI_RESPONDER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CLKS = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ena;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic [15:0] self_v [4];
    logic [7:0]  head_o;
    logic [15:0] data_o [4];
    logic        rdy_o;
    logic        fault_o;
    logic        ovr_o;

    always #5 clk = ~clk;

    cmi_packet_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_ena     (rx_ena),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .cmi_self0  (self_v[0]),
        .cmi_self1  (self_v[1]),
        .cmi_self2  (self_v[2]),
        .cmi_self3  (self_v[3]),
        .cmi_head   (head_o),
        .cmi_data0  (data_o[0]),
        .cmi_data1  (data_o[1]),
        .cmi_data2  (data_o[2]),
        .cmi_data3  (data_o[3]),
        .cmi_rdy    (rdy_o),
        .cmi_fault  (fault_o),
        .cmi_overrun(ovr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    bit          m_in_frame = 1'b0;
    logic [7:0]  m_fb [11];
    int          m_n = 0;
    int          m_idle = 0;
    bit          m_rdy = 1'b0;
    bit          m_fault = 1'b0;
    logic [7:0]  m_head = 8'd0;
    logic [15:0] m_data [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
    logic [7:0]  m_q [$];
    int          m_earliest = 0;
    logic [7:0]  m_last = 8'd0;

    // Event monitor
    int          rdy_cnt = 0;
    int          fault_cnt = 0;
    int          ovr_cnt = 0;
    int          tx_cnt = 0;
    int          rdy_cyc = 0;
    logic [7:0]  tx_log [$];
    int          en_cyc [$];

    int          busy_mode = 0;
    logic [7:0]  fr_buf [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_n        = 0;
        m_idle     = 0;
        m_rdy      = 1'b0;
        m_fault    = 1'b0;
        m_head     = 8'd0;
        for (int i = 0; i < 4; i++) m_data[i] = 16'd0;
        m_q.delete();
        m_last     = 8'd0;
    endfunction

    always @(negedge clk) begin
        bit         exp_en;
        bit         had_pending;
        logic [7:0] hdr;
        logic [7:0] cs;
        cyc++;
        if (!rst_n) begin
            chk("reset_ctrl", {tx_enable, rdy_o, fault_o, ovr_o, tx_data, head_o}, 32'd0);
            chk("reset_data01", {data_o[0], data_o[1]}, 32'd0);
            chk("reset_data23", {data_o[2], data_o[3]}, 32'd0);
            model_reset();
        end else begin
            had_pending = (m_q.size() != 0);
            exp_en = had_pending && (cyc >= m_earliest) && !tx_busy;
            chk("cmi_rdy", rdy_o, m_rdy);
            chk("cmi_fault", fault_o, m_fault);
            chk("cmi_overrun", ovr_o, m_rdy && had_pending);
            chk("cmi_head", head_o, m_head);
            for (int i = 0; i < 4; i++) chk($sformatf("cmi_data%0d", i), data_o[i], m_data[i]);
            chk("tx_enable", tx_enable, exp_en);
            chk("tx_data", tx_data, exp_en ? m_q[0] : m_last);

            if (rdy_o) begin
                rdy_cnt++;
                rdy_cyc = cyc;
            end
            if (fault_o) fault_cnt++;
            if (ovr_o) ovr_cnt++;
            if (tx_enable) begin
                chk("tx_enable_while_busy", tx_busy, 1'b0);
                tx_cnt++;
                tx_log.push_back(tx_data);
                en_cyc.push_back(cyc);
            end

            if (exp_en) begin
                m_last = m_q.pop_front();
                m_earliest = cyc + 2;
            end
            if (m_rdy && !had_pending) begin
                hdr = {m_head[7:2], 2'b01};
                cs = hdr;
                m_q.push_back(8'hA5);
                m_q.push_back(hdr);
                for (int i = 0; i < 4; i++) begin
                    m_q.push_back(self_v[i][15:8]);
                    m_q.push_back(self_v[i][7:0]);
                    cs = cs ^ self_v[i][15:8] ^ self_v[i][7:0];
                end
                m_q.push_back(cs);
                m_earliest = cyc + 2;
            end

            m_rdy = 1'b0;
            m_fault = 1'b0;
            if (!m_in_frame) begin
                if (rx_ena && rx_data == 8'hA5) begin
                    m_in_frame = 1'b1;
                    m_n = 0;
                    m_idle = 0;
                end
            end else if (rx_ena) begin
                m_fb[m_n] = rx_data;
                m_n++;
                m_idle = 0;
                if (m_n == 10) begin
                    m_in_frame = 1'b0;
                    cs = 8'd0;
                    for (int i = 0; i < 9; i++) cs = cs ^ m_fb[i];
                    if (cs == m_fb[9]) begin
                        m_head = m_fb[0];
                        for (int i = 0; i < 4; i++) m_data[i] = {m_fb[1 + 2 * i], m_fb[2 + 2 * i]};
                        m_rdy = 1'b1;
                    end else begin
                        m_fault = 1'b1;
                    end
                end
            end else if (TO_EN) begin
                m_idle++;
                if (m_idle == TO_CLKS) begin
                    m_fault = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
        end
    end

    // UART transmitter stand-in: busy for a random time after each strobe, optionally with random extra busy.
    initial begin
        int  busy_cnt;
        bit  strobe;
        busy_cnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            strobe = tx_enable;
            @(posedge clk);
            #1;
            if (strobe) begin
                busy_cnt = (busy_mode != 0) ? int'($urandom_range(3, 8)) : int'($urandom_range(0, 2));
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt > 0) || (busy_mode == 2 && $urandom_range(0, 3) == 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_ena = 1'b1;
        @(posedge clk);
        #1;
        rx_ena = 1'b0;
        idle(gap);
    endtask

    task automatic make_frame(input logic [7:0] h, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d, input bit bad);
        logic [7:0] cs;
        fr_buf[0] = 8'hA5;
        fr_buf[1] = h;
        {fr_buf[2], fr_buf[3]} = a;
        {fr_buf[4], fr_buf[5]} = b;
        {fr_buf[6], fr_buf[7]} = c;
        {fr_buf[8], fr_buf[9]} = d;
        cs = 8'd0;
        for (int i = 1; i < 10; i++) cs = cs ^ fr_buf[i];
        fr_buf[10] = bad ? (cs ^ 8'($urandom_range(1, 255))) : cs;
    endtask

    task automatic send_range(input int from, input int to, input int maxgap);
        for (int i = from; i <= to; i++) send_byte(fr_buf[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        idle(2);
        while ((m_q.size() != 0 || m_in_frame) && k < budget) begin
            idle(1);
            k++;
        end
        idle(3);
        chk("drain", m_q.size(), 0);
    endtask

    initial begin
        logic [7:0] exp_reply [11];
        int r0;
        int f0;
        int o0;
        int t0;
        int k;
        exp_reply = '{8'hA5, 8'h0D, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D};
        rst_n = 1'b0;
        rx_ena = 1'b0;
        rx_data = 8'd0;
        for (int i = 0; i < 4; i++) self_v[i] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Bad checksum first, so outputs must remain at reset values
        make_frame(8'h0C, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0);
        fr_buf[10] = 8'h2B;
        send_range(0, 10, 0);
        idle(20);
        $display("frame bad_csum sent");
        chk("bad_fault_cnt", fault_cnt, 1);
        chk("bad_rdy_cnt", rdy_cnt, 0);
        chk("bad_tx_cnt", tx_cnt, 0);
        chk("bad_head", head_o, 8'h00);
        chk("bad_data0", data_o[0], 16'h0000);

        // Reference frame with hand-computed reply
        self_v[0] = 16'hAAAA;
        self_v[1] = 16'h5555;
        tx_log.delete();
        en_cyc.delete();
        make_frame(8'h0C, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0);
        fr_buf[10] = 8'h2A;
        send_range(0, 10, 0);
        wait_drain(500);
        $display("frame ref head=0c done, %0d reply bytes", tx_log.size());
        chk("ref_head", head_o, 8'h0C);
        chk("ref_data0", data_o[0], 16'h1234);
        chk("ref_rdy_cnt", rdy_cnt, 1);
        chk("ref_reply_len", tx_log.size(), 11);
        for (int i = 0; i < 11 && i < tx_log.size(); i++) chk($sformatf("ref_reply_b%0d", i), tx_log[i], exp_reply[i]);
        if (en_cyc.size() > 0) chk("ref_first_strobe_latency", en_cyc[0] - rdy_cyc, 2);

        // Garbage before a valid frame
        r0 = rdy_cnt;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h13, 0);
        make_frame(8'h20, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b0);
        send_range(0, 10, 1);
        wait_drain(500);
        $display("frame garbage+head=20 done");
        chk("garb_rdy", rdy_cnt - r0, 1);
        chk("garb_head", head_o, 8'h20);
        chk("garb_data3", data_o[3], 16'h0708);

        // Stall after D1H
        r0 = rdy_cnt;
        f0 = fault_cnt;
        make_frame(8'h24, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
        send_range(0, 4, 0);
        idle(TO_CLKS + 100);
        if (TO_EN) begin
            chk("timeout_fault", fault_cnt - f0, 1);
            send_range(0, 10, 0);
        end else begin
            chk("stall_no_fault", fault_cnt - f0, 0);
            send_range(5, 10, 0);
        end
        wait_drain(500);
        $display("frame stalled head=24 done");
        chk("stall_rdy", rdy_cnt - r0, 1);
        chk("stall_head", head_o, 8'h24);
        chk("stall_data1", data_o[1], 16'h2222);

        // Second frame completes during the first reply
        busy_mode = 1;
        r0 = rdy_cnt;
        o0 = ovr_cnt;
        t0 = tx_cnt;
        self_v[2] = 16'h1357;
        make_frame(8'h30, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0);
        send_range(0, 10, 0);
        make_frame(8'h34, 16'hBEEF, 16'h0, 16'h0, 16'h0, 1'b0);
        send_range(0, 10, 0);
        wait_drain(1000);
        $display("frame overrun head=34 done");
        chk("ovr_cnt", ovr_cnt - o0, 1);
        chk("ovr_rdy", rdy_cnt - r0, 2);
        chk("ovr_data0", data_o[0], 16'hBEEF);
        chk("ovr_tx_bytes", tx_cnt - t0, 11);

        // Reset after the fifth reply byte
        t0 = tx_cnt;
        make_frame(8'h40, 16'hCAFE, 16'h0, 16'h0, 16'h0, 1'b0);
        send_range(0, 10, 0);
        k = 0;
        while (tx_cnt - t0 < 5 && k < 500) begin
            idle(1);
            k++;
        end
        chk("rst_reach5", tx_cnt - t0, 5);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        t0 = tx_cnt;
        idle(40);
        $display("reset mid-reply done");
        chk("rst_no_tx", tx_cnt - t0, 0);
        chk("rst_head", head_o, 8'h00);
        make_frame(8'h44, 16'h0F0F, 16'h0, 16'h0, 16'h0, 1'b0);
        send_range(0, 10, 0);
        wait_drain(1000);
        chk("rst_full_reply", tx_cnt - t0, 11);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] g;
            bit bad;
            busy_mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 4; i++) self_v[i] = 16'($urandom);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, int'($urandom_range(0, 2)));
            end
            bad = ($urandom_range(0, 3) == 0);
            make_frame(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), bad);
            send_range(0, 10, int'($urandom_range(0, 3)));
            $display("random frame %0d head=%02h bad=%0d", n, fr_buf[1], bad);
            idle(int'($urandom_range(0, 30)));
        end
        busy_mode = 0;
        wait_drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
